// File: rtl/switch_pkg.sv
// Shared constants and types for the crossbar connection scheduler.
package switch_pkg;

    localparam int NPORT  = 4;
    localparam int LEN_W  = 12;
    localparam int PSEL_W = $clog2(NPORT);

    typedef enum logic [1:0] {IDLE, XFER, GAP} xconn_state_t;

    // Gap counter only has to count 0..gap_cyc-1.
    function automatic int gap_cnt_w(input int gap_cyc);
        return (gap_cyc < 2) ? 1 : $clog2(gap_cyc);
    endfunction

endpackage

// File: rtl/xbar_port_ctrl.sv
// Per-tx connection controller: holds one rx->tx connection for a frame,
// counts beats down, then enforces the inter-frame gap.
module xbar_port_ctrl
    import switch_pkg::*;
#(
    parameter int GAP_CYC = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [PSEL_W-1:0] load_sel,
    input  logic [LEN_W-1:0]  load_len,
    input  logic [NPORT-1:0]  src_valid,
    input  logic              tx_ready,
    output logic              xbar_en,
    output logic [PSEL_W-1:0] xbar_sel,
    output logic              beat_last,
    output logic              port_idle,
    output logic              port_free
);

    localparam int GAP_W = gap_cnt_w(GAP_CYC);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

    xconn_state_t     state;
    xconn_state_t     state_nxt;
    logic [LEN_W-1:0] cnt;
    logic [GAP_W-1:0] gcnt;
    logic             beat;
    logic             done;

    assign beat = (state == XFER) && src_valid[xbar_sel] && tx_ready;
    assign done = beat && (cnt == LEN_W'(1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // With no gap, a port finishing its last beat can be re-matched in the same cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (load) state_nxt = XFER;
            XFER: begin
                if (done) begin
                    if (GAP_CYC > 0) state_nxt = GAP;
                    else if (!load)  state_nxt = IDLE;
                end
            end
            GAP:  if (gcnt == GAP_LAST) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        xbar_en   = (state == XFER);
        beat_last = xbar_en && (cnt == LEN_W'(1));
        port_idle = (state == IDLE);
        port_free = port_idle || ((GAP_CYC == 0) && done);
    end

    // A zero-length descriptor is carried as a single beat.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt      <= '0;
            gcnt     <= '0;
            xbar_sel <= '0;
        end else begin
            if (load) begin
                cnt      <= (load_len == '0) ? LEN_W'(1) : load_len;
                xbar_sel <= load_sel;
            end else if (beat) begin
                cnt <= cnt - 1'b1;
            end
            gcnt <= (state == GAP) ? gcnt + 1'b1 : '0;
        end
    end

endmodule

// File: rtl/xbar_conn_sched.sv
// Connection scheduler between the iSLIP arbiter and the crossbar datapath:
// validates match rows, launches per-tx connections and reports port status.
module xbar_conn_sched
    import switch_pkg::*;
#(
    parameter int GAP_CYC = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    match_valid,
    output logic                    match_ready,
    input  logic [NPORT*NPORT-1:0]  match_vect,
    input  logic [NPORT*LEN_W-1:0]  rx_len,
    output logic [NPORT-1:0]        rx_pop,
    input  logic [NPORT-1:0]        src_valid,
    input  logic [NPORT-1:0]        tx_ready,
    input  logic [NPORT-1:0]        tx_free,
    output logic [NPORT-1:0]        tx_rdy_vect,
    output logic [NPORT-1:0]        rx_idle_vect,
    output logic [NPORT-1:0]        xbar_en,
    output logic [NPORT*PSEL_W-1:0] xbar_sel,
    output logic [NPORT-1:0]        beat_last,
    output logic                    err
);

    logic [NPORT-1:0]  port_idle;
    logic [NPORT-1:0]  port_free;
    logic [NPORT-1:0]  onehot;
    logic [NPORT-1:0]  seen_tx;
    logic [NPORT-1:0]  dup_tx;
    logic [NPORT-1:0]  row;
    logic [NPORT-1:0]  accept;
    logic [NPORT-1:0]  row_bad;
    logic [NPORT-1:0]  load;
    logic              len_zero;
    logic [PSEL_W-1:0] load_sel [NPORT];
    logic [LEN_W-1:0]  load_len [NPORT];
    logic [PSEL_W-1:0] sel      [NPORT];

    assign match_ready = 1'b1;
    assign tx_rdy_vect = tx_free & port_idle;

    // Rows that collide on a tx are all dropped, so duplicates are found first.
    always_comb begin
        seen_tx = '0;
        dup_tx  = '0;
        onehot  = '0;
        row     = '0;
        accept  = '0;
        row_bad = '0;
        for (int r = 0; r < NPORT; r++) begin
            row       = match_vect[r*NPORT +: NPORT];
            onehot[r] = (row != '0) && ((row & (row - 1'b1)) == '0);
            if (onehot[r]) begin
                dup_tx  = dup_tx | (seen_tx & row);
                seen_tx = seen_tx | row;
            end
        end
        for (int r = 0; r < NPORT; r++) begin
            row        = match_vect[r*NPORT +: NPORT];
            accept[r]  = match_valid && onehot[r] && rx_idle_vect[r] &&
                         ((row & ~dup_tx & port_free) != '0);
            row_bad[r] = match_valid && (row != '0) && !accept[r];
        end
    end

    always_comb begin
        load     = '0;
        len_zero = 1'b0;
        for (int t = 0; t < NPORT; t++) begin
            load_sel[t] = '0;
            load_len[t] = '0;
        end
        for (int r = 0; r < NPORT; r++) begin
            if (accept[r] && (rx_len[r*LEN_W +: LEN_W] == '0)) len_zero = 1'b1;
            for (int t = 0; t < NPORT; t++) begin
                if (accept[r] && match_vect[r*NPORT + t]) begin
                    load[t]     = 1'b1;
                    load_sel[t] = PSEL_W'(r);
                    load_len[t] = rx_len[r*LEN_W +: LEN_W];
                end
            end
        end
    end

    always_comb begin
        rx_idle_vect = '1;
        for (int t = 0; t < NPORT; t++) begin
            for (int r = 0; r < NPORT; r++) begin
                if (xbar_en[t] && (sel[t] == PSEL_W'(r))) rx_idle_vect[r] = 1'b0;
            end
        end
    end

    for (genvar t = 0; t < NPORT; t++) begin : g_port
        xbar_port_ctrl #(.GAP_CYC(GAP_CYC)) u_port (
            .clk       (clk),
            .rst       (rst),
            .load      (load[t]),
            .load_sel  (load_sel[t]),
            .load_len  (load_len[t]),
            .src_valid (src_valid),
            .tx_ready  (tx_ready[t]),
            .xbar_en   (xbar_en[t]),
            .xbar_sel  (sel[t]),
            .beat_last (beat_last[t]),
            .port_idle (port_idle[t]),
            .port_free (port_free[t])
        );
        assign xbar_sel[t*PSEL_W +: PSEL_W] = sel[t];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_pop <= '0;
            err    <= 1'b0;
        end else begin
            rx_pop <= accept;
            if ((row_bad != '0) || len_zero) err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_xbar_conn_sched.sv
// Bench for xbar_conn_sched: a GAP_CYC=3 and a GAP_CYC=0 instance share stimulus
// and are compared every cycle against a frame-level reference model.
module tb_xbar_conn_sched;
    import switch_pkg::*;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    match_valid;
    logic [NPORT*NPORT-1:0]  match_vect;
    logic [NPORT*LEN_W-1:0]  rx_len;
    logic [NPORT-1:0]        src_valid, tx_ready, tx_free;

    logic                    mr  [2];
    logic [NPORT-1:0]        pop [2];
    logic [NPORT-1:0]        trv [2];
    logic [NPORT-1:0]        riv [2];
    logic [NPORT-1:0]        en  [2];
    logic [NPORT-1:0]        bl  [2];
    logic [NPORT*PSEL_W-1:0] sel [2];
    logic                    er  [2];

    int n_vec = 0;
    int n_bad = 0;

    // Reference state: beats still owed, gap cycles left, source rx per tx.
    int               rem [2][NPORT];
    int               gl  [2][NPORT];
    int               src [2][NPORT];
    logic [NPORT-1:0] m_pop [2];
    logic             m_err [2];

    always #5 clk = ~clk;

    xbar_conn_sched #(.GAP_CYC(3)) u_dut_gap3 (
        .clk(clk), .rst(rst), .match_valid(match_valid), .match_ready(mr[0]),
        .match_vect(match_vect), .rx_len(rx_len), .rx_pop(pop[0]),
        .src_valid(src_valid), .tx_ready(tx_ready), .tx_free(tx_free),
        .tx_rdy_vect(trv[0]), .rx_idle_vect(riv[0]), .xbar_en(en[0]),
        .xbar_sel(sel[0]), .beat_last(bl[0]), .err(er[0])
    );

    xbar_conn_sched #(.GAP_CYC(0)) u_dut_gap0 (
        .clk(clk), .rst(rst), .match_valid(match_valid), .match_ready(mr[1]),
        .match_vect(match_vect), .rx_len(rx_len), .rx_pop(pop[1]),
        .src_valid(src_valid), .tx_ready(tx_ready), .tx_free(tx_free),
        .tx_rdy_vect(trv[1]), .rx_idle_vect(riv[1]), .xbar_en(en[1]),
        .xbar_sel(sel[1]), .beat_last(bl[1]), .err(er[1])
    );

    function automatic int gap_of(input int k);
        return (k == 0) ? 3 : 0;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int t = 0; t < NPORT; t++) begin
                rem[k][t] = 0;
                gl[k][t]  = 0;
                src[k][t] = 0;
            end
            m_pop[k] = '0;
            m_err[k] = 1'b0;
        end
    endtask

    task automatic check_outputs();
        for (int k = 0; k < 2; k++) begin
            logic [NPORT-1:0]        e_en, e_last, e_idle, e_rx;
            logic [NPORT*PSEL_W-1:0] e_sel;
            e_en = '0; e_last = '0; e_idle = '0; e_rx = '1; e_sel = '0;
            for (int t = 0; t < NPORT; t++) begin
                e_en[t]   = rem[k][t] > 0;
                e_last[t] = rem[k][t] == 1;
                e_idle[t] = (rem[k][t] == 0) && (gl[k][t] == 0);
                e_sel[t*PSEL_W +: PSEL_W] = PSEL_W'(src[k][t]);
                if (rem[k][t] > 0) e_rx[src[k][t]] = 1'b0;
            end
            check_eq($sformatf("xbar_en[%0d]", k), en[k], e_en);
            check_eq($sformatf("xbar_sel[%0d]", k), sel[k], e_sel);
            check_eq($sformatf("beat_last[%0d]", k), bl[k], e_last);
            check_eq($sformatf("tx_rdy_vect[%0d]", k), trv[k], tx_free & e_idle);
            check_eq($sformatf("rx_idle_vect[%0d]", k), riv[k], e_rx);
            check_eq($sformatf("rx_pop[%0d]", k), pop[k], m_pop[k]);
            check_eq($sformatf("err[%0d]", k), er[k], m_err[k]);
            check_eq($sformatf("match_ready[%0d]", k), mr[k], 1'b1);
        end
    endtask

    // One clock of the frame-level model, using the inputs currently applied.
    task automatic model_advance();
        for (int k = 0; k < 2; k++) begin
            logic [NPORT-1:0] beat, freev, rx_conn, acc, rowv;
            int               tgt_cnt [NPORT];
            int               tgt     [NPORT];
            int               len;
            logic             bad;
            beat = '0; freev = '0; rx_conn = '0; acc = '0; bad = 1'b0;
            for (int t = 0; t < NPORT; t++) begin
                beat[t]  = (rem[k][t] > 0) && src_valid[src[k][t]] && tx_ready[t];
                freev[t] = ((rem[k][t] == 0) && (gl[k][t] == 0)) ||
                           ((gap_of(k) == 0) && (rem[k][t] == 1) && beat[t]);
                if (rem[k][t] > 0) rx_conn[src[k][t]] = 1'b1;
                tgt_cnt[t] = 0;
            end
            for (int r = 0; r < NPORT; r++) begin
                rowv   = match_vect[r*NPORT +: NPORT];
                tgt[r] = -1;
                if ($countones(rowv) == 1) begin
                    for (int t = 0; t < NPORT; t++) if (rowv[t]) tgt[r] = t;
                    tgt_cnt[tgt[r]]++;
                end
            end
            if (match_valid) begin
                for (int r = 0; r < NPORT; r++) begin
                    rowv = match_vect[r*NPORT +: NPORT];
                    if (tgt[r] >= 0 && tgt_cnt[tgt[r]] == 1 && freev[tgt[r]] && !rx_conn[r])
                        acc[r] = 1'b1;
                    else if (rowv != '0)
                        bad = 1'b1;
                end
            end
            for (int t = 0; t < NPORT; t++) begin
                if (beat[t]) begin
                    rem[k][t]--;
                    if (rem[k][t] == 0) gl[k][t] = gap_of(k);
                end else if (rem[k][t] == 0 && gl[k][t] > 0) begin
                    gl[k][t]--;
                end
            end
            for (int r = 0; r < NPORT; r++) begin
                if (acc[r]) begin
                    len = int'(rx_len[r*LEN_W +: LEN_W]);
                    if (len == 0) begin
                        bad = 1'b1;
                        len = 1;
                    end
                    rem[k][tgt[r]] = len;
                    src[k][tgt[r]] = r;
                end
            end
            m_pop[k] = acc;
            if (bad) m_err[k] = 1'b1;
        end
    endtask

    task automatic drive(input logic mv, input logic [NPORT*NPORT-1:0] mvect,
                         input logic [NPORT-1:0] sv, input logic [NPORT-1:0] tr,
                         input logic [NPORT-1:0] tf);
        match_valid = mv;
        match_vect  = mvect;
        src_valid   = sv;
        tx_ready    = tr;
        tx_free     = tf;
    endtask

    task automatic set_lens(input int l0, input int l1, input int l2, input int l3);
        rx_len = {LEN_W'(l3), LEN_W'(l2), LEN_W'(l1), LEN_W'(l0)};
    endtask

    task automatic adv();
        check_outputs();
        model_advance();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic cycle();
        #1;
        adv();
    endtask

    task automatic do_reset();
        rst = 1'b0;
        drive(1'b0, '0, '1, '1, '1);
        set_lens(0, 0, 0, 0);
        model_reset();
        #1;
        for (int k = 0; k < 2; k++) begin
            check_eq($sformatf("rst_xbar_en[%0d]", k), en[k], 4'h0);
            check_eq($sformatf("rst_rx_idle[%0d]", k), riv[k], 4'hF);
            check_eq($sformatf("rst_err[%0d]", k), er[k], 1'b0);
        end
        check_outputs();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        int nb, ne, pick;
        logic [NPORT*NPORT-1:0] mv_rand;
        logic [NPORT-1:0]       sv_r, tr_r, tf_r;

        rst = 1'b0;
        drive(1'b0, '0, '1, '1, '1);
        set_lens(0, 0, 0, 0);
        model_reset();
        @(negedge clk);
        do_reset();

        // Single connection rx0->tx1, four beats, then the gap.
        set_lens(4, 0, 0, 0);
        drive(1'b1, 16'h0002, 4'hF, 4'hF, 4'hF);
        cycle();
        for (int i = 1; i <= 9; i++) begin
            drive(1'b0, '0, 4'hF, 4'hF, 4'hF);
            #1;
            check_eq("s2_pop", pop[0], (i == 1) ? 4'h1 : 4'h0);
            check_eq("s2_en1", en[0][1], i <= 4);
            check_eq("s2_sel1", sel[0][3:2], 2'd0);
            check_eq("s2_last1", bl[0][1], i == 4);
            check_eq("s2_rdy1", trv[0][1], i >= 8);
            adv();
        end

        // Backpressure on tx1: three beats spread over five cycles.
        do_reset();
        set_lens(3, 0, 0, 0);
        drive(1'b1, 16'h0002, 4'hF, 4'hF, 4'hF);
        cycle();
        nb = 0;
        ne = 0;
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, '0, 4'hF, (i % 2 == 0) ? 4'hF : 4'hD, 4'hF);
            #1;
            if (en[0][1]) ne++;
            if (en[0][1] && tx_ready[1]) nb++;
            adv();
        end
        check_eq("s3_beats", nb, 3);
        check_eq("s3_held", ne, 5);

        // Full diagonal match, then reset while all four are mid-frame.
        do_reset();
        set_lens(5, 5, 5, 5);
        drive(1'b1, 16'h8421, 4'hF, 4'hF, 4'hF);
        cycle();
        drive(1'b0, '0, 4'hF, 4'hF, 4'hF);
        #1;
        check_eq("s4_sel", sel[0], 8'hE4);
        check_eq("s4_rx_idle", riv[0], 4'h0);
        check_eq("s4_en", en[0], 4'hF);
        check_eq("s4_pop", pop[0], 4'hF);
        adv();
        cycle();
        do_reset();

        // Conflicting rows: only rx3->tx3 survives and err sticks.
        set_lens(2, 2, 2, 2);
        drive(1'b1, 16'h8344, 4'hF, 4'hF, 4'hF);
        cycle();
        drive(1'b0, '0, 4'hF, 4'hF, 4'hF);
        #1;
        check_eq("s5_pop", pop[0], 4'h8);
        check_eq("s5_en", en[0], 4'h8);
        check_eq("s5_err", er[0], 1'b1);
        adv();
        for (int i = 0; i < 10; i++) cycle();
        #1;
        check_eq("s5_err_sticky", er[0], 1'b1);
        adv();

        // Zero-gap instance: release and re-match tx2 in the same cycle.
        do_reset();
        set_lens(2, 3, 0, 0);
        drive(1'b1, 16'h0004, 4'hF, 4'hF, 4'hF);
        cycle();
        drive(1'b0, '0, 4'hF, 4'hF, 4'hF);
        cycle();
        drive(1'b1, 16'h0040, 4'hF, 4'hF, 4'hF);
        #1;
        check_eq("s6_last2", bl[1][2], 1'b1);
        adv();
        drive(1'b0, '0, 4'hF, 4'hF, 4'hF);
        #1;
        check_eq("s6_sel2", sel[1][5:4], 2'd1);
        check_eq("s6_en2", en[1][2], 1'b1);
        check_eq("s6_pop", pop[1], 4'h2);
        check_eq("s6_err", er[1], 1'b0);
        adv();

        // Randomized traffic with occasional mid-run resets.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if (i % 700 == 350) begin
                do_reset();
            end else begin
                for (int r = 0; r < NPORT; r++) begin
                    pick = $urandom_range(0, 9);
                    if (pick < 4)      mv_rand[r*NPORT +: NPORT] = '0;
                    else if (pick < 9) mv_rand[r*NPORT +: NPORT] = NPORT'(1) << $urandom_range(0, NPORT - 1);
                    else               mv_rand[r*NPORT +: NPORT] = NPORT'($urandom_range(0, 15));
                    rx_len[r*LEN_W +: LEN_W] = LEN_W'($urandom_range(0, 6));
                end
                for (int p = 0; p < NPORT; p++) begin
                    sv_r[p] = ($urandom_range(0, 9) < 8);
                    tr_r[p] = ($urandom_range(0, 9) < 8);
                    tf_r[p] = ($urandom_range(0, 9) < 9);
                end
                drive(($urandom_range(0, 3) != 0), mv_rand, sv_r, tr_r, tf_r);
                cycle();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
